// File: rtl/systolic_stream_sorter_if.sv
// Stream handshake bundle between a key producer/consumer and the systolic sorter.
// The producer/consumer side uses master and the sorter uses slave.
interface systolic_stream_sorter_if #(
  parameter int NUMINPUTS = 16,
  parameter int WIDTH     = 16
);
  logic                               in_valid;
  logic                               in_ready;
  logic [WIDTH-1:0]                   in_data;
  logic                               in_last;
  logic                               desc;
  logic                               out_valid;
  logic                               out_ready;
  logic [WIDTH-1:0]                   out_data;
  logic                               out_last;
  logic [$clog2(NUMINPUTS+1)-1:0]     count;

  modport master (
    output in_valid, in_data, in_last, desc, out_ready,
    input  in_ready, out_valid, out_data, out_last, count
  );

  modport slave (
    input  in_valid, in_data, in_last, desc, out_ready,
    output in_ready, out_valid, out_data, out_last, count
  );
endinterface

// File: rtl/systolic_stream_sorter.sv
// Insertion-style systolic sorter: keys are placed in rank order as they arrive,
// then the batch is shifted out of cell 0 in order.
module systolic_stream_sorter #(
  parameter int NUMINPUTS = 16,
  parameter int WIDTH     = 16
) (
  input logic                     clk,
  input logic                     reset,
  systolic_stream_sorter_if.slave bus
);
  localparam int CW = $clog2(NUMINPUTS+1);
  localparam logic [0:0] LOAD  = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;

  logic [0:0]       state;
  logic [CW-1:0]    cnt;
  logic             desc_lat;
  logic [WIDTH-1:0] key     [NUMINPUTS];
  logic [WIDTH-1:0] key_nxt [NUMINPUTS];
  logic [NUMINPUTS-1:0] occ;
  logic [NUMINPUTS-1:0] occ_nxt;
  logic [NUMINPUTS-1:0] keep;
  logic             accept;
  logic             pop;
  logic             desc_eff;

  // Strict ordering so an equal incoming key lands after existing equal keys.
  function automatic logic ranks_before(input logic [WIDTH-1:0] a,
                                        input logic [WIDTH-1:0] b,
                                        input logic             dsc);
    return dsc ? (a > b) : (a < b);
  endfunction

  assign accept   = bus.in_valid && (state == LOAD);
  assign pop      = bus.out_ready && (state == DRAIN);
  assign desc_eff = (cnt == '0) ? bus.desc : desc_lat;

  always_comb begin
    for (int i = 0; i < NUMINPUTS; i++) begin
      keep[i] = occ[i] && !ranks_before(bus.in_data, key[i], desc_eff);
    end
  end

  always_comb begin
    key_nxt = key;
    occ_nxt = occ;
    if (accept) begin
      if (!keep[0]) begin
        key_nxt[0] = bus.in_data;
        occ_nxt[0] = 1'b1;
      end
      for (int i = 1; i < NUMINPUTS; i++) begin
        if (!keep[i]) begin
          if (keep[i-1]) begin
            key_nxt[i] = bus.in_data;
            occ_nxt[i] = 1'b1;
          end else begin
            key_nxt[i] = key[i-1];
            occ_nxt[i] = occ[i-1];
          end
        end
      end
    end else if (pop) begin
      for (int i = 0; i < NUMINPUTS-1; i++) begin
        key_nxt[i] = key[i+1];
        occ_nxt[i] = occ[i+1];
      end
      key_nxt[NUMINPUTS-1] = '0;
      occ_nxt[NUMINPUTS-1] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= LOAD;
      cnt      <= '0;
      desc_lat <= 1'b0;
      occ      <= '0;
      for (int i = 0; i < NUMINPUTS; i++) key[i] <= '0;
    end else begin
      key <= key_nxt;
      occ <= occ_nxt;
      if (accept) begin
        cnt <= cnt + 1'b1;
        if (cnt == '0) desc_lat <= bus.desc;
        if (bus.in_last || (cnt == CW'(NUMINPUTS-1))) state <= DRAIN;
      end else if (pop) begin
        cnt <= cnt - 1'b1;
        if (cnt == CW'(1)) state <= LOAD;
      end
    end
  end

  assign bus.in_ready  = (state == LOAD);
  assign bus.out_valid = (state == DRAIN);
  assign bus.out_data  = key[0];
  assign bus.out_last  = (cnt == CW'(1));
  assign bus.count     = cnt;
endmodule
